// File: rtl/mac_accum_requant_pkg.sv
// Shared types and fixed-point helpers for the MAC accumulate/requantize stage
// and other datapath stages that narrow a wide sum back to layer precision.
package mac_accum_requant_pkg;

    typedef enum logic [1:0] {ACCUM, REQUANT, HOLD} state_t;

    // Accumulator width: full product width, growth for n_terms, plus one guard bit.
    function automatic int acc_width(input int bits, input int n_terms);
        return 2 * bits + $clog2(n_terms) + 1;
    endfunction

    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                     input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/mac_accum_requant_if.sv
// Product-in / result-out handshake bundle for mac_accum_requant.
interface mac_accum_requant_if #(
    parameter int BITS = 17
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [2*BITS-1:0] prod_in;
    logic signed [BITS-1:0]   bias;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [BITS-1:0]   out_data;

    modport master (
        output in_valid, prod_in, bias, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, prod_in, bias, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/requant_sat.sv
// Combinational bias add, round-half-up, arithmetic shift, saturation and
// optional ReLU from an ACC_W sum down to BITS/NFRAC fixed point.
module requant_sat
    import mac_accum_requant_pkg::*;
#(
    parameter int BITS  = 17,
    parameter int NFRAC = 8,
    parameter int ACC_W = 37,
    parameter int RELU  = 1
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [BITS-1:0]  bias,
    output logic signed [BITS-1:0]  res
);
    localparam int T_W = ACC_W + 1;

    logic signed [T_W-1:0] acc_x;
    logic signed [T_W-1:0] bias_x;
    logic signed [T_W-1:0] half;
    logic signed [T_W-1:0] t;
    logic signed [63:0]    r_x;

    always_comb begin
        acc_x  = {{(T_W-ACC_W){acc[ACC_W-1]}}, acc};
        bias_x = {{(T_W-BITS){bias[BITS-1]}}, bias} <<< NFRAC;
        half   = '0;
        half[NFRAC-1] = 1'b1;
        t      = acc_x + bias_x + half;
        r_x    = $signed({{(64-T_W){t[T_W-1]}}, t}) >>> NFRAC;
        // ReLU before the clamp gives the same result as after it, since 0 is in range.
        if (RELU != 0 && r_x < 0)
            r_x = '0;
        res = BITS'(sat_clamp(r_x, BITS));
    end
endmodule

// File: rtl/mac_accum_requant.sv
// Accumulates N_TERMS signed products, then requantizes sum+bias into a
// one-entry valid/ready output register.
//
//   state   | meaning
//   ACCUM   | accepting products into the accumulator
//   REQUANT | one cycle: register rounded/saturated result, clear accumulator
//   HOLD    | result held until taken; may accept next sum's first product
module mac_accum_requant
    import mac_accum_requant_pkg::*;
#(
    parameter int BITS    = 17,
    parameter int NFRAC   = 8,
    parameter int N_TERMS = 16,
    parameter int RELU    = 1
) (
    input logic                clk,
    input logic                reset,
    mac_accum_requant_if.slave bus
);
    localparam int ACC_W = acc_width(BITS, N_TERMS);
    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    state_t                  state;
    state_t                  state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_x;
    logic [CNT_W-1:0]        cnt;
    logic                    accept;
    logic                    last;
    logic signed [BITS-1:0]  res;

    always_comb begin
        bus.in_ready = 1'b0;
        if (!reset) begin
            case (state)
                ACCUM:   bus.in_ready = 1'b1;
                HOLD:    bus.in_ready = bus.out_ready;
                default: bus.in_ready = 1'b0;
            endcase
        end
    end

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (cnt == CNT_W'(N_TERMS - 1));
    assign prod_x = {{(ACC_W-2*BITS){bus.prod_in[2*BITS-1]}}, bus.prod_in};

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: begin
                if (accept && last)
                    state_nxt = REQUANT;
            end
            REQUANT: state_nxt = HOLD;
            HOLD: begin
                // With N_TERMS=1 the overlapped beat already completes the next sum.
                if (bus.out_ready)
                    state_nxt = (accept && last) ? REQUANT : ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ACCUM;
            acc           <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            state <= state_nxt;
            if (state == REQUANT) begin
                bus.out_data  <= res;
                bus.out_valid <= 1'b1;
                acc           <= '0;
            end else if (accept) begin
                acc <= acc + prod_x;
                cnt <= last ? '0 : cnt + CNT_W'(1);
            end
            if (state == HOLD && bus.out_ready)
                bus.out_valid <= 1'b0;
        end
    end

    requant_sat #(
        .BITS  (BITS),
        .NFRAC (NFRAC),
        .ACC_W (ACC_W),
        .RELU  (RELU)
    ) u_requant_sat (
        .acc  (acc),
        .bias (bus.bias),
        .res  (res)
    );
endmodule
